instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential MIPS instruction encoder and instruction-memory loader: the write-side counterpart of the CPU's opcode decoder. It accepts one symbolic instruction per handshake and packs it into a 32-bit word using exactly the opcode set the decoder recognises. It then writes the word to consecutive instruction-memory addresses. It sits between the testbench/boot stimulus and the instruction memory, ahead of the CPU's fetch path.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width. Depth is DEPTH = 2^ADDR_W.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  begin or restart a load session (one-cycle pulse).
- `in_valid_i`  in  1  instruction fields valid.
- `in_ready_o`  out  1  encoder accepts fields this cycle.
- `mnem_i`  in  5  mnemonic code (see Operation).
- `rs_i` / `rt_i` / `rd_i` / `shamt_i`  in  5 each  register and shift fields.
- `imm_i`  in  16  I-type immediate.
- `target_i`  in  26  J-type target.
- `im_we_o`  out  1  instruction-memory write request.
- `im_ready_i`  in  1  memory accepts the write this cycle.
- `im_addr_o`  out  ADDR_W  write word address.
- `im_data_o`  out  32  encoded instruction.
- `count_o`  out  ADDR_W+1  number of completed writes this session.
- `full_o`  out  1  last address has been issued.
- `err_o`  out  1  sticky illegal-mnemonic flag.

## Operation
- **Mnemonic codes and encodings:**
  - R-type (op 0) with funct: 0 ADD (0x20), 1 SUB (0x22), 2 AND (0x24), 3 OR (0x25), 4 SLT (0x2A), 5 SLL (0x00), 6 JR (0x08).
  - J-type: 7 J (op 2), 8 JAL (op 3).
  - I-type: 9 BEQ (4), 10 BNE (5), 11 BLT (6), 12 BLE (7), 13 ADDI (8), 14 ORI (13), 15 LI (15), 16 LW (35), 17 SW (43).
  - Codes 18–31 are illegal.
- **Field layouts:**
  - R: {op,rs,rt,rd,shamt,funct}.
  - I: {op,rs,rt,imm}.
  - J: {op,target}.
- **Forced-zero fields:**
  - shamt for every R-type except SLL.
  - rs for SLL.
  - rt, rd and shamt for JR.
  - rs for LI.
  - BNEZ is BNE with the caller supplying rt=0; it has no dedicated code.
- **FSM states:** IDLE, RUN, FULL.
  - Reset enters IDLE.
  - `start_i` in any state enters RUN. It also clears the next-address register, `count_o` and `err_o`, and drops any pending write.
  - RUN goes to FULL when a legal instruction is accepted at address DEPTH-1.
  - FULL leaves only on `start_i` or reset.
- **Input handshake:**
  - `in_ready_o` = RUN & !`start_i` & (!`im_we_o` | `im_ready_i`).
  - A transfer occurs when `in_valid_i` & `in_ready_o`.
- **Legal transfer:**
  - Register `im_data_o`, and register `im_addr_o` = next address.
  - Set `im_we_o`; increment the next address.
- **Illegal transfer:**
  - Handshake completes, but no write is made and the address does not advance.
  - Set `err_o` (sticky until `start_i` or reset).
- **Write completion:**
  - A write completes when `im_we_o` & `im_ready_i`.
  - `count_o` increments, saturating at DEPTH.
  - `im_we_o` clears unless a new transfer is accepted in the same cycle.
- `full_o` = (state == FULL).

## Timing
- **Reset values:** `in_ready_o`=0, `im_we_o`=0, `im_addr_o`=0, `im_data_o`=0, `count_o`=0, `full_o`=0, `err_o`=0. State is IDLE.
- **Latency:** transfer on edge N gives `im_we_o`/`im_addr_o`/`im_data_o` valid after edge N, i.e. in cycle N+1.
- `im_we_o`, `im_addr_o` and `im_data_o` hold stable while `im_we_o` & !`im_ready_i`.
- **Back-to-back:** with `im_ready_i` held high, one write per cycle with no bubbles. Completion and a new acceptance may occur in the same cycle.
- **`start_i` during a pending write:** the write is abandoned and `im_we_o`=0 after the edge. `count_o` is not incremented, even if `im_ready_i` was high that cycle.
- **FULL:** `in_ready_o`=0. The final pending write still completes, and `count_o` reaches DEPTH.
- **Async reset mid-session:** all outputs return to reset values immediately; no write completes.

## Structure
- Package `instr_enc_pkg` holds:
  - mnemonic code constants;
  - opcode and funct constants, shared with decoder-side checks;
  - FSM state encoding.
- Sub-module `instr_field_packer` is purely combinational. It maps mnem plus fields to {word[31:0], legal}. The top module holds the FSM, address/count registers and the output register.

## Test plan
- **Encode ADD and LW:** reset; pulse start; send ADD rs=1 rt=2 rd=3, then LW rs=29 rt=8 imm=4, with `im_ready_i`=1.
  - Expect 0x00221820 @0 in cycle after accept, then 0x8FA80004 @1 on the next cycle.
  - Expect `count_o`=2.
- **Encode J-type, branch and forced zeros:** JAL target=0x10 -> 0x0C000010; BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF; JR rs=31 with rt=rd=shamt=5 -> 0x03E00008.
- **Backpressure:** hold `im_ready_i`=0 for 3 cycles after the first accept.
  - Expect `in_ready_o`=0, and `im_*` stable.
  - On release, the write completes and the next instruction is accepted in the same cycle.
- **Illegal mnemonic:** mnem=20 between two ADDs.
  - Expect `err_o`=1 and writes only at addresses 0 and 1; `count_o`=2.
  - Then start gives `err_o`=0.
- **Fill:** ADDR_W=2; stream 5 instructions.
  - Expect 4 accepted, `full_o`=1 after the 4th, `count_o`=4, 5th `in_valid_i` never acknowledged.
- **Restart and reset:** pulse start with a write pending and `im_ready_i`=0.
  - Expect `im_we_o`=0, address restarts at 0, `count_o`=0.
  - Assert `rst_i`=0 mid-stream: expect all outputs 0 without a clock edge.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// instr_enc_pkg: mnemonic codes, MIPS opcode/funct constants and encoder FSM states
package instr_enc_pkg;
   localparam logic [4:0] M_ADD  = 5'd0;
   localparam logic [4:0] M_SUB  = 5'd1;
   localparam logic [4:0] M_AND  = 5'd2;
   localparam logic [4:0] M_OR   = 5'd3;
   localparam logic [4:0] M_SLT  = 5'd4;
   localparam logic [4:0] M_SLL  = 5'd5;
   localparam logic [4:0] M_JR   = 5'd6;
   localparam logic [4:0] M_J    = 5'd7;
   localparam logic [4:0] M_JAL  = 5'd8;
   localparam logic [4:0] M_BEQ  = 5'd9;
   localparam logic [4:0] M_BNE  = 5'd10;
   localparam logic [4:0] M_BLT  = 5'd11;
   localparam logic [4:0] M_BLE  = 5'd12;
   localparam logic [4:0] M_ADDI = 5'd13;
   localparam logic [4:0] M_ORI  = 5'd14;
   localparam logic [4:0] M_LI   = 5'd15;
   localparam logic [4:0] M_LW   = 5'd16;
   localparam logic [4:0] M_SW   = 5'd17;

   localparam logic [5:0] OP_R    = 6'd0;
   localparam logic [5:0] OP_J    = 6'd2;
   localparam logic [5:0] OP_JAL  = 6'd3;
   localparam logic [5:0] OP_BEQ  = 6'd4;
   localparam logic [5:0] OP_BNE  = 6'd5;
   localparam logic [5:0] OP_BLT  = 6'd6;
   localparam logic [5:0] OP_BLE  = 6'd7;
   localparam logic [5:0] OP_ADDI = 6'd8;
   localparam logic [5:0] OP_ORI  = 6'd13;
   localparam logic [5:0] OP_LI   = 6'd15;
   localparam logic [5:0] OP_LW   = 6'd35;
   localparam logic [5:0] OP_SW   = 6'd43;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;
   localparam logic [5:0] F_SLL = 6'h00;
   localparam logic [5:0] F_JR  = 6'h08;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: stimulus-side handshake and instruction-memory write bus of the encoder
interface instr_encoder_if #(parameter int ADDR_W = 8);
   logic              start_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [4:0]        mnem_i;
   logic [4:0]        rs_i;
   logic [4:0]        rt_i;
   logic [4:0]        rd_i;
   logic [4:0]        shamt_i;
   logic [15:0]       imm_i;
   logic [25:0]       target_i;
   logic              im_we_o;
   logic              im_ready_i;
   logic [ADDR_W-1:0] im_addr_o;
   logic [31:0]       im_data_o;
   logic [ADDR_W:0]   count_o;
   logic              full_o;
   logic              err_o;

   modport slave (
      input  start_i, in_valid_i, mnem_i, rs_i, rt_i, rd_i, shamt_i, imm_i, target_i, im_ready_i,
      output in_ready_o, im_we_o, im_addr_o, im_data_o, count_o, full_o, err_o
   );

   modport master (
      output start_i, in_valid_i, mnem_i, rs_i, rt_i, rd_i, shamt_i, imm_i, target_i, im_ready_i,
      input  in_ready_o, im_we_o, im_addr_o, im_data_o, count_o, full_o, err_o
   );
endinterface

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational mnemonic + fields -> 32-bit MIPS word and legality flag
module instr_field_packer
   import instr_enc_pkg::*;
(
   input  logic [4:0]  mnem,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        legal
);
   // pack fields per format, zeroing the fields each opcode ignores
   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (mnem)
         M_ADD:   word = {OP_R, rs, rt, rd, 5'd0, F_ADD};
         M_SUB:   word = {OP_R, rs, rt, rd, 5'd0, F_SUB};
         M_AND:   word = {OP_R, rs, rt, rd, 5'd0, F_AND};
         M_OR:    word = {OP_R, rs, rt, rd, 5'd0, F_OR};
         M_SLT:   word = {OP_R, rs, rt, rd, 5'd0, F_SLT};
         M_SLL:   word = {OP_R, 5'd0, rt, rd, shamt, F_SLL};
         M_JR:    word = {OP_R, rs, 15'd0, F_JR};
         M_J:     word = {OP_J, target};
         M_JAL:   word = {OP_JAL, target};
         M_BEQ:   word = {OP_BEQ, rs, rt, imm};
         M_BNE:   word = {OP_BNE, rs, rt, imm};
         M_BLT:   word = {OP_BLT, rs, rt, imm};
         M_BLE:   word = {OP_BLE, rs, rt, imm};
         M_ADDI:  word = {OP_ADDI, rs, rt, imm};
         M_ORI:   word = {OP_ORI, rs, rt, imm};
         M_LI:    word = {OP_LI, 5'd0, rt, imm};
         M_LW:    word = {OP_LW, rs, rt, imm};
         M_SW:    word = {OP_SW, rs, rt, imm};
         default: legal = 1'b0;
      endcase
   end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts symbolic instructions, encodes them and writes them to consecutive imem words
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   instr_encoder_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

   state_t state, state_nx;
   logic [ADDR_W-1:0] next_addr;
   logic [31:0] word;
   logic legal, xfer, take, done;

   instr_field_packer u_pack (
      .mnem   (bus.mnem_i),
      .rs     (bus.rs_i),
      .rt     (bus.rt_i),
      .rd     (bus.rd_i),
      .shamt  (bus.shamt_i),
      .imm    (bus.imm_i),
      .target (bus.target_i),
      .word   (word),
      .legal  (legal)
   );

   assign bus.in_ready_o = (state == S_RUN) & ~bus.start_i & (~bus.im_we_o | bus.im_ready_i);
   assign bus.full_o     = (state == S_FULL);
   assign xfer = bus.in_valid_i & bus.in_ready_o;
   assign take = xfer & legal;
   assign done = bus.im_we_o & bus.im_ready_i & ~bus.start_i;

   // state register
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) state <= S_IDLE;
      else state <= state_nx;

   // start always (re)enters RUN; a legal accept at the last address fills the memory
   always_comb begin
      state_nx = bus.start_i ? S_RUN : (state == S_RUN && take && &next_addr) ? S_FULL : state;
   end

   // output register, address/count tracking and sticky error
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         bus.im_we_o   <= 1'b0;
         bus.im_addr_o <= '0;
         bus.im_data_o <= '0;
         bus.count_o   <= '0;
         bus.err_o     <= 1'b0;
         next_addr     <= '0;
      end else if (bus.start_i) begin
         bus.im_we_o <= 1'b0;
         bus.count_o <= '0;
         bus.err_o   <= 1'b0;
         next_addr   <= '0;
      end else begin
         if (done && bus.count_o != CNT_MAX) bus.count_o <= bus.count_o + 1'b1;
         if (take) begin
            bus.im_we_o   <= 1'b1;
            bus.im_addr_o <= next_addr;
            bus.im_data_o <= word;
            next_addr     <= next_addr + 1'b1;
         end else if (done) bus.im_we_o <= 1'b0;
         if (xfer && !legal) bus.err_o <= 1'b1;
      end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench with directed and randomized sessions against a table-driven encoder model
module tb_instr_encoder;
   import instr_enc_pkg::*;
   localparam int AW = 2;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_W(AW)) bus ();
   instr_encoder #(.ADDR_W(AW)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

   typedef struct packed {logic [AW-1:0] a; logic [31:0] d;} exp_t;
   exp_t exp_q[$];
   int checks = 0;
   int failures = 0;
   int m_legal = 0;
   logic [AW-1:0] m_next = '0;
   bit m_err = 1'b0;
   bit rand_ready = 1'b0;
   int unsigned op_tab[18] = '{0, 0, 0, 0, 0, 0, 0, 2, 3, 4, 5, 6, 7, 8, 13, 15, 35, 43};
   int unsigned fn_tab[7] = '{32, 34, 36, 37, 42, 0, 8};

   function automatic logic [31:0] ref_word(input logic [4:0] m, input logic [4:0] rs, rt, rd, sh,
                                            input logic [15:0] imm, input logic [25:0] tgt);
      int unsigned mi;
      mi = 32'(m);
      if (mi >= 18) return 32'd0;
      if (mi < 7)
         return ((mi == 5) ? 0 : 32'(rs)) * (1 << 21) + ((mi == 6) ? 0 : 32'(rt)) * (1 << 16)
              + ((mi == 6) ? 0 : 32'(rd)) * (1 << 11) + ((mi == 5) ? 32'(sh) : 0) * (1 << 6) + fn_tab[mi];
      if (mi < 9) return op_tab[mi] * (1 << 26) + 32'(tgt);
      return op_tab[mi] * (1 << 26) + ((mi == 15) ? 0 : 32'(rs)) * (1 << 21) + 32'(rt) * (1 << 16) + 32'(imm);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready_o), 0);
      check({tag, "_we"}, 32'(bus.im_we_o), 0);
      check({tag, "_addr"}, 32'(bus.im_addr_o), 0);
      check({tag, "_data"}, bus.im_data_o, 0);
      check({tag, "_count"}, 32'(bus.count_o), 0);
      check({tag, "_full"}, 32'(bus.full_o), 0);
      check({tag, "_err"}, 32'(bus.err_o), 0);
   endtask

   // scoreboard monitor: every completed write must match the oldest expected one
   always @(negedge clk) begin
      if (rst_n && bus.im_we_o && bus.im_ready_i && !bus.start_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write addr=%0d data=0x%08h expected none", bus.im_addr_o, bus.im_data_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("write_addr", 32'(bus.im_addr_o), 32'(e.a));
            check("write_data", bus.im_data_o, e.d);
         end
      end
   end

   task automatic send(input logic [4:0] m, input logic [4:0] rs, rt, rd, sh, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] exp_w, input bit exp_ok, input int budget,
                       output bit acc, output int waited);
      bus.mnem_i = m; bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd; bus.shamt_i = sh;
      bus.imm_i = imm; bus.target_i = tgt; bus.in_valid_i = 1'b1;
      acc = 1'b0;
      waited = 0;
      while (!acc && waited < budget) begin
         if (rand_ready) bus.im_ready_i = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (bus.in_ready_o) begin
            acc = 1'b1;
            if (exp_ok) begin
               exp_q.push_back({m_next, exp_w});
               m_next++;
               m_legal++;
            end else m_err = 1'b1;
         end else waited++;
         @(posedge clk);
         #1;
      end
      bus.in_valid_i = 1'b0;
   endtask

   task automatic send_ref(input logic [4:0] m, input logic [4:0] rs, rt, rd, sh, input logic [15:0] imm,
                           input logic [25:0] tgt, input int budget, output bit acc);
      int w;
      send(m, rs, rt, rd, sh, imm, tgt, ref_word(m, rs, rt, rd, sh, imm, tgt), m < 18, budget, acc, w);
   endtask

   task automatic session_start();
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      exp_q.delete();
      m_next = '0;
      m_legal = 0;
      m_err = 1'b0;
   endtask

   task automatic drain(input string tag);
      bus.im_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_queue_left"}, 32'(exp_q.size()), 0);
      check({tag, "_count"}, 32'(bus.count_o), 32'((m_legal > DEPTH) ? DEPTH : m_legal));
      check({tag, "_err"}, 32'(bus.err_o), 32'(m_err));
      check({tag, "_full"}, 32'(bus.full_o), 32'(m_legal >= DEPTH));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      bit acc;
      int w;
      bus.start_i = 0; bus.in_valid_i = 0; bus.mnem_i = 0; bus.rs_i = 0; bus.rt_i = 0; bus.rd_i = 0;
      bus.shamt_i = 0; bus.imm_i = 0; bus.target_i = 0; bus.im_ready_i = 0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_in_ready", 32'(bus.in_ready_o), 0);

      // encode ADD/LW/JAL/BEQ, filling the 4-word memory
      session_start();
      bus.im_ready_i = 1'b1;
      send(M_ADD, 1, 2, 3, 0, 0, 0, 32'h00221820, 1, 10, acc, w);
      send(M_LW, 29, 8, 0, 0, 16'h0004, 0, 32'h8FA80004, 1, 10, acc, w);
      check("t1_count_after_first", 32'(bus.count_o), 1);
      send(M_JAL, 0, 0, 0, 0, 0, 26'h10, 32'h0C000010, 1, 10, acc, w);
      check("t1_count_two", 32'(bus.count_o), 2);
      send(M_BEQ, 1, 2, 0, 0, 16'hFFFF, 0, 32'h1022FFFF, 1, 10, acc, w);
      check("t1_full", 32'(bus.full_o), 1);
      check("t1_full_in_ready", 32'(bus.in_ready_o), 0);
      drain("t1");

      // forced-zero fields
      session_start();
      send(M_JR, 31, 5, 5, 5, 0, 0, 32'h03E00008, 1, 10, acc, w);
      send(M_SLL, 7, 2, 4, 3, 0, 0, 32'h000220C0, 1, 10, acc, w);
      send(M_LI, 9, 4, 0, 0, 16'h1234, 0, 32'h3C041234, 1, 10, acc, w);
      drain("t2");

      // backpressure
      session_start();
      bus.im_ready_i = 1'b0;
      send(M_ADD, 1, 2, 3, 0, 0, 0, 32'h00221820, 1, 10, acc, w);
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", 32'(bus.in_ready_o), 0);
         check("bp_we", 32'(bus.im_we_o), 1);
         check("bp_addr", 32'(bus.im_addr_o), 0);
         check("bp_data", bus.im_data_o, 32'h00221820);
      end
      @(posedge clk);
      #1;
      bus.im_ready_i = 1'b1;
      send(M_SUB, 4, 5, 6, 0, 0, 0, 32'h00853022, 1, 10, acc, w);
      check("bp_release_wait", 32'(w), 0);
      drain("t3");

      // illegal mnemonic between two ADDs
      session_start();
      send(M_ADD, 1, 2, 3, 0, 0, 0, 32'h00221820, 1, 10, acc, w);
      send(5'd20, 1, 2, 3, 0, 0, 0, 32'h0, 0, 10, acc, w);
      check("ill_accepted", 32'(acc), 1);
      send(M_ADD, 0, 0, 7, 0, 0, 0, 32'h00003820, 1, 10, acc, w);
      drain("t4");
      session_start();
      check("ill_err_cleared", 32'(bus.err_o), 0);

      // fill: five offered, four accepted
      session_start();
      for (int i = 0; i < 5; i++) begin
         send_ref(M_ADDI, 5'(i), 5'(i + 1), 0, 0, 16'(i * 3), 0, (i < 4) ? 10 : 6, acc);
         check("fill_accept", 32'(acc), 32'(i < 4));
         if (i == 3) check("fill_full_after_4th", 32'(bus.full_o), 1);
      end
      drain("t5");

      // start abandons a pending write
      session_start();
      bus.im_ready_i = 1'b0;
      send(M_ADD, 1, 2, 3, 0, 0, 0, 32'h00221820, 1, 10, acc, w);
      bus.im_ready_i = 1'b1;
      session_start();
      check("restart_we", 32'(bus.im_we_o), 0);
      check("restart_count", 32'(bus.count_o), 0);
      send(M_OR, 1, 2, 3, 0, 0, 0, 32'h00221825, 1, 10, acc, w);
      drain("t6");

      // asynchronous reset mid-session
      session_start();
      bus.im_ready_i = 1'b0;
      send(M_ADD, 1, 2, 3, 0, 0, 0, 32'h00221820, 1, 10, acc, w);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_idle", 32'(bus.in_ready_o), 0);

      // randomized sessions
      for (int s = 0; s < 20; s++) begin
         int n;
         session_start();
         rand_ready = 1'b1;
         n = $urandom_range(1, 7);
         for (int k = 0; k < n; k++) begin
            logic [4:0] m;
            bit exp_acc;
            m = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
            exp_acc = m_legal < DEPTH;
            send_ref(m, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                     26'($urandom), exp_acc ? 40 : 4, acc);
            check("rand_accept", 32'(acc), 32'(exp_acc));
         end
         rand_ready = 1'b0;
         drain("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
